pipe_stage: RTL and testbench

//  Parametrised inter-stage pipeline register; generic successor to the fixed EX/MEM latch.

---
 rtl/pipe_stage_pkg.sv | 22 ++
 rtl/pipe_stage_if.sv | 31 +++
 rtl/pipe_stage_skid_slot.sv | 34 +++
 rtl/pipe_stage.sv | 103 ++++++++++
 tb/tb_pipe_stage.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the generic inter-stage pipeline register: per-stage bundle
// widths, the bubble control value and the per-edge action encoding.
package pipe_stage_pkg;

  localparam int IDEX_CTRLSIZE  = 12;
  localparam int IDEX_DATASIZE  = 128;
  localparam int EXMEM_CTRLSIZE = 8;
  localparam int EXMEM_DATASIZE = 64;
  localparam int MEMWB_CTRLSIZE = 4;
  localparam int MEMWB_DATASIZE = 72;

  // A bubble carries an all-zero control bundle.
  localparam logic BUBBLE_CTRL_BIT = 1'b0;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_DRAIN = 2'd3
  } stage_act_e;

endpackage

// File: rtl/pipe_stage_if.sv
// Handshake/payload bundle between an upstream stage (master) and a pipe_stage (slave).
interface pipe_stage_if
  import pipe_stage_pkg::*;
#(
  parameter int CTRLSIZE = EXMEM_CTRLSIZE,
  parameter int DATASIZE = EXMEM_DATASIZE,
  parameter int CNTSIZE  = 16
);
  logic                stall;
  logic                flush;
  logic                nop;
  logic                validin;
  logic                nopin;
  logic [CTRLSIZE-1:0] controlin;
  logic [DATASIZE-1:0] datain;
  logic                readyout;
  logic                nopout;
  logic [CTRLSIZE-1:0] controlout;
  logic [DATASIZE-1:0] dataout;
  logic [CNTSIZE-1:0]  bubblecount;

  modport master (
    output stall, flush, nop, validin, nopin, controlin, datain,
    input  readyout, nopout, controlout, dataout, bubblecount
  );

  modport slave (
    input  stall, flush, nop, validin, nopin, controlin, datain,
    output readyout, nopout, controlout, dataout, bubblecount
  );
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One-entry holding register with a full flag; clear beats load beats drain.
module skid_slot #(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0] word_p1;
  logic         full_p1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full_p1 <= 1'b0;
    end else if (load) begin
      full_p1 <= 1'b1;
    end else if (drain) begin
      full_p1 <= 1'b0;
    end
    if (load) begin
      word_p1 <= din;
    end
  end

  assign dout = word_p1;
  assign full = full_p1;

endmodule

// File: rtl/pipe_stage.sv
// Parametrised pipeline register with stall, flush, local bubble insertion, optional
// skid slot (registered ready) and a saturating bubble counter.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int CTRLSIZE = EXMEM_CTRLSIZE,
  parameter int DATASIZE = EXMEM_DATASIZE,
  parameter int SKID     = 0,
  parameter int CNTSIZE  = 16
) (
  input  logic        clk,
  input  logic        reset,
  pipe_stage_if.slave bus
);

  localparam int W = 1 + CTRLSIZE + DATASIZE;

  function automatic logic [CNTSIZE-1:0] sat_inc(input logic [CNTSIZE-1:0] v);
    return (&v) ? v : v + {{(CNTSIZE-1){1'b0}}, 1'b1};
  endfunction

  logic                accept;
  logic                in_nop;
  logic [W-1:0]        in_word;
  logic [W-1:0]        skid_word;
  logic                skid_full;
  logic                skid_load;
  logic                skid_drain;
  stage_act_e          act;

  logic                nop_p1;
  logic [CTRLSIZE-1:0] ctrl_p1;
  logic [DATASIZE-1:0] data_p1;
  logic [CNTSIZE-1:0]  cnt_p1;

  // Input side: an unaccepted cycle is a bubble; nop is resolved before any capture.
  assign accept  = bus.validin && bus.readyout;
  assign in_nop  = bus.nop || bus.nopin || !accept;
  assign in_word = {in_nop, in_nop ? {CTRLSIZE{BUBBLE_CTRL_BIT}} : bus.controlin, bus.datain};

  assign skid_load  = !bus.flush && accept && (bus.stall || skid_full);
  assign skid_drain = !bus.flush && !bus.stall && skid_full;

  generate
    if (SKID != 0) begin : g_skid
      skid_slot #(.W(W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .load  (skid_load),
        .drain (skid_drain),
        .din   (in_word),
        .dout  (skid_word),
        .full  (skid_full)
      );
      assign bus.readyout = !skid_full;
    end else begin : g_noskid
      assign skid_word    = '0;
      assign skid_full    = 1'b0;
      assign bus.readyout = !bus.stall;
    end
  endgenerate

  always_comb begin
    act = ACT_LOAD;
    if (bus.flush) begin
      act = ACT_FLUSH;
    end else if (bus.stall) begin
      act = ACT_HOLD;
    end else if (skid_full) begin
      act = ACT_DRAIN;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      nop_p1  <= 1'b1;
      ctrl_p1 <= '0;
      data_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      if (nop_p1) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
      case (act)
        ACT_FLUSH: begin
          nop_p1  <= 1'b1;
          ctrl_p1 <= {CTRLSIZE{BUBBLE_CTRL_BIT}};
        end
        ACT_DRAIN: {nop_p1, ctrl_p1, data_p1} <= skid_word;
        ACT_LOAD:  {nop_p1, ctrl_p1, data_p1} <= in_word;
        default:   ;
      endcase
    end
  end

  assign bus.nopout      = nop_p1;
  assign bus.controlout  = ctrl_p1;
  assign bus.dataout     = data_p1;
  assign bus.bubblecount = cnt_p1;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: combinational-ready, skid and narrow-counter variants.
module tb_pipe_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_if #(.CTRLSIZE(8), .DATASIZE(64), .CNTSIZE(16)) b0 ();
  pipe_stage_if #(.CTRLSIZE(8), .DATASIZE(64), .CNTSIZE(16)) b1 ();
  pipe_stage_if #(.CTRLSIZE(8), .DATASIZE(64), .CNTSIZE(4))  b2 ();

  pipe_stage #(.CTRLSIZE(8), .DATASIZE(64), .SKID(0), .CNTSIZE(16)) u0 (.clk(clk), .reset(reset), .bus(b0));
  pipe_stage #(.CTRLSIZE(8), .DATASIZE(64), .SKID(1), .CNTSIZE(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
  pipe_stage #(.CTRLSIZE(8), .DATASIZE(64), .SKID(0), .CNTSIZE(4))  u2 (.clk(clk), .reset(reset), .bus(b2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] c, input logic [63:0] d);
    b0.validin = v; b0.controlin = c; b0.datain = d;
  endtask

  task automatic drive1(input logic v, input logic [7:0] c, input logic [63:0] d);
    b1.validin = v; b1.controlin = c; b1.datain = d;
  endtask

  initial begin
    reset = 1'b1;
    {b0.stall, b0.flush, b0.nop, b0.validin, b0.nopin} = '0; b0.controlin = '0; b0.datain = '0;
    {b1.stall, b1.flush, b1.nop, b1.validin, b1.nopin} = '0; b1.controlin = '0; b1.datain = '0;
    {b2.stall, b2.flush, b2.nop, b2.validin, b2.nopin} = '0; b2.controlin = '0; b2.datain = '0;

    // reset state
    step(); step();
    check("rst_nop",   b0.nopout, 1);
    check("rst_ctrl",  b0.controlout, 0);
    check("rst_data",  b0.dataout, 0);
    check("rst_cnt",   b0.bubblecount, 0);
    check("rst_ready", b1.readyout, 1);
    reset = 1'b0;
    step(); check("cnt1", b0.bubblecount, 1);
    step(); check("cnt2", b0.bubblecount, 2);

    // SKID=0 valid words A, B
    drive0(1, 8'h5A, 64'hAAAA_0001);
    step();
    check("A_ctrl", b0.controlout, 8'h5A);
    check("A_data", b0.dataout, 64'hAAAA_0001);
    check("A_nop",  b0.nopout, 0);
    check("A_cnt",  b0.bubblecount, 3);
    drive0(1, 8'h3C, 64'hBBBB_0002);
    step();
    check("B_ctrl", b0.controlout, 8'h3C);
    check("B_data", b0.dataout, 64'hBBBB_0002);
    check("B_cnt",  b0.bubblecount, 3);

    // incoming bubble and local nop request
    b0.nopin = 1; drive0(1, 8'hFF, 64'h1234);
    step();
    check("nopin_ctrl", b0.controlout, 0);
    check("nopin_nop",  b0.nopout, 1);
    check("nopin_data", b0.dataout, 64'h1234);
    b0.nopin = 0; b0.nop = 1; drive0(1, 8'h11, 64'h5678);
    step();
    check("nop_ctrl", b0.controlout, 0);
    check("nop_nop",  b0.nopout, 1);
    check("nop_data", b0.dataout, 64'h5678);
    b0.nop = 0;

    // SKID=0 stall holds, word offered during stall is dropped
    drive0(1, 8'h77, 64'h77);
    step();
    check("s0_load", b0.controlout, 8'h77);
    b0.stall = 1; drive0(1, 8'h88, 64'h88);
    #1; check("s0_ready", b0.readyout, 0);
    step();
    check("s0_hold_ctrl", b0.controlout, 8'h77);
    check("s0_hold_data", b0.dataout, 64'h77);
    b0.stall = 0; b0.validin = 0;
    #1; check("s0_ready_back", b0.readyout, 1);
    step();
    check("s0_novalid_nop",  b0.nopout, 1);
    check("s0_novalid_data", b0.dataout, 64'h88);

    // SKID=0 flush keeps data, kills control
    drive0(1, 8'h99, 64'h99);
    step();
    b0.flush = 1; drive0(1, 8'hAB, 64'hAB);
    step();
    check("fl_nop",  b0.nopout, 1);
    check("fl_ctrl", b0.controlout, 0);
    check("fl_data", b0.dataout, 64'h99);
    b0.flush = 0; b0.validin = 0;

    // SKID=1: A at output, stall 3 cycles, B then C offered
    drive1(1, 8'hA1, 64'hA1);
    step();
    check("k_A", b1.controlout, 8'hA1);
    b1.stall = 1; drive1(1, 8'hB2, 64'hB2);
    step();
    check("k_hold1", b1.controlout, 8'hA1);
    check("k_ready1", b1.readyout, 0);
    drive1(1, 8'hC3, 64'hC3);
    step();
    check("k_hold2", b1.controlout, 8'hA1);
    step();
    check("k_hold3",  b1.dataout, 64'hA1);
    check("k_ready3", b1.readyout, 0);
    b1.stall = 0;
    step();
    check("k_B_ctrl", b1.controlout, 8'hB2);
    check("k_B_data", b1.dataout, 64'hB2);
    check("k_B_nop",  b1.nopout, 0);
    check("k_ready4", b1.readyout, 1);
    step();
    check("k_C_ctrl", b1.controlout, 8'hC3);
    check("k_C_data", b1.dataout, 64'hC3);
    b1.validin = 0;
    step();
    check("k_idle_nop", b1.nopout, 1);

    // SKID=1: flush + stall with skid full
    drive1(1, 8'hD4, 64'hD4);
    step();
    b1.stall = 1; drive1(1, 8'hE5, 64'hE5);
    step();
    check("kf_full", b1.readyout, 0);
    b1.flush = 1; drive1(1, 8'hF6, 64'hF6);
    step();
    check("kf_nop",   b1.nopout, 1);
    check("kf_ctrl",  b1.controlout, 0);
    check("kf_data",  b1.dataout, 64'hD4);
    check("kf_ready", b1.readyout, 1);
    b1.flush = 0; b1.stall = 0; b1.validin = 0;
    step();
    check("kf_noE_nop",  b1.nopout, 1);
    check("kf_noE_ctrl", b1.controlout, 0);

    // SKID=1: reset with skid full discards it
    drive1(1, 8'h17, 64'h17);
    step();
    b1.stall = 1; drive1(1, 8'h28, 64'h28);
    step();
    check("kr_full", b1.readyout, 0);
    reset = 1; b1.validin = 0; b1.stall = 0;
    step();
    check("kr_ready", b1.readyout, 1);
    check("kr_nop",   b1.nopout, 1);
    check("kr_data",  b1.dataout, 0);
    check("kr_cnt2",  b2.bubblecount, 0);
    reset = 0;

    // CNTSIZE=4 saturation under continuous bubbles
    for (int i = 0; i < 14; i++) step();
    check("kr_after_nop", b1.nopout, 1);
    check("sat_E", b2.bubblecount, 4'hE);
    for (int i = 0; i < 6; i++) step();
    check("sat_F", b2.bubblecount, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
